// File: rtl/game_flow_pkg.sv
// Shared types and default IR codes for the game flow sequencer.
package game_flow_pkg;

  localparam int unsigned IR_W     = 32;
  localparam int unsigned HEALTH_W = 3;
  localparam int unsigned DIGIT_W  = 2;
  localparam int unsigned STATE_W  = 3;

  localparam logic [IR_W-1:0] IR_START_A = 32'h20DF_5BA4;
  localparam logic [IR_W-1:0] IR_START_B = 32'h20DF_5AA5;
  localparam logic [IR_W-1:0] IR_RESTART = 32'h20DF_10EF;

  typedef enum logic [STATE_W-1:0] {
    S_START     = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_WIN       = 3'd3,
    S_LOSE      = 3'd4,
    S_DRAW      = 3'd5
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// IR/frame/health inputs and screen-select outputs of the game flow sequencer.
interface game_flow_controller_if;
  import game_flow_pkg::*;

  logic [IR_W-1:0]     ir_in;
  logic                ir_valid_in;
  logic                nf_in;
  logic [HEALTH_W-1:0] player_health_in;
  logic [HEALTH_W-1:0] opponent_health_in;

  logic                display_start_out;
  logic                countdown_active_out;
  logic [DIGIT_W-1:0]  countdown_digit_out;
  logic                game_active_out;
  logic                end_win_out;
  logic                end_lose_out;
  logic                end_draw_out;
  logic                health_reset_out;
  logic [STATE_W-1:0]  state_out;

  modport master (
    output ir_in, ir_valid_in, nf_in, player_health_in, opponent_health_in,
    input  display_start_out, countdown_active_out, countdown_digit_out,
           game_active_out, end_win_out, end_lose_out, end_draw_out,
           health_reset_out, state_out
  );

  modport slave (
    input  ir_in, ir_valid_in, nf_in, player_health_in, opponent_health_in,
    output display_start_out, countdown_active_out, countdown_digit_out,
           game_active_out, end_win_out, end_lose_out, end_draw_out,
           health_reset_out, state_out
  );
endinterface

// File: rtl/frame_tick_counter.sv
// Saturating frame-tick counter with synchronous clear; clear wins over tick.
module frame_tick_counter #(
  parameter int unsigned TERMINAL = 120,
  parameter int unsigned CNT_W    = $clog2(TERMINAL + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             tick_i,
  output logic [CNT_W-1:0] count_o,
  output logic             terminal_o
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TERMINAL);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i && (count_q != TERM)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign terminal_o = (count_q == TERM);

endmodule

// File: rtl/game_flow_controller.sv
// Game sequencer: start menu, countdown, play and end screens driven by IR codes,
// frame ticks and health values; all outputs registered from the next state.
module game_flow_controller
  import game_flow_pkg::*;
#(
  parameter logic [IR_W-1:0] START_CODE_A     = IR_START_A,
  parameter logic [IR_W-1:0] START_CODE_B     = IR_START_B,
  parameter logic [IR_W-1:0] RESTART_CODE     = IR_RESTART,
  parameter int unsigned     COUNT_DIGITS     = 3,
  parameter int unsigned     FRAMES_PER_DIGIT = 60,
  parameter int unsigned     END_HOLD_FRAMES  = 120
) (
  input logic                   clk_in,
  input logic                   rst_in,
  game_flow_controller_if.slave bus
);

  localparam int unsigned CNT_MAX = max_u(FRAMES_PER_DIGIT, END_HOLD_FRAMES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   DIGIT_LAST  = CNT_W'(FRAMES_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0]   HOLD_CNT    = CNT_W'(END_HOLD_FRAMES);
  localparam logic [DIGIT_W-1:0] DIGIT_FIRST = DIGIT_W'(COUNT_DIGITS);

  state_e               state_q, state_d;
  logic [DIGIT_W-1:0]   digit_q, digit_d;
  logic                 armed_q, armed_d;
  logic                 hold_done_q, hold_done_d;

  logic                 disp_start_q, disp_start_d;
  logic                 cd_active_q, cd_active_d;
  logic [DIGIT_W-1:0]   cd_digit_q, cd_digit_d;
  logic                 game_q, game_d;
  logic                 win_q, win_d;
  logic                 lose_q, lose_d;
  logic                 draw_q, draw_d;
  logic                 hr_q, hr_d;
  logic [STATE_W-1:0]   state_out_q, state_out_d;

  logic                 cnt_clear_c;
  logic [CNT_W-1:0]     cnt;
  logic                 cnt_term;
  logic                 ir_start_c, ir_restart_c;
  logic                 player_dead_c, opp_dead_c;
  logic                 hold_ok_c;

  frame_tick_counter #(
    .TERMINAL (CNT_MAX),
    .CNT_W    (CNT_W)
  ) u_frame_cnt (
    .clk_i      (clk_in),
    .rst_ni     (rst_in),
    .clear_i    (cnt_clear_c),
    .tick_i     (bus.nf_in),
    .count_o    (cnt),
    .terminal_o (cnt_term)
  );

  assign ir_start_c    = bus.ir_valid_in &&
                         ((bus.ir_in == START_CODE_A) || (bus.ir_in == START_CODE_B));
  assign ir_restart_c  = bus.ir_valid_in && (bus.ir_in == RESTART_CODE);
  assign player_dead_c = (bus.player_health_in == '0);
  assign opp_dead_c    = (bus.opponent_health_in == '0);
  // A saturated counter has necessarily passed the hold count.
  assign hold_ok_c     = hold_done_q || (cnt == HOLD_CNT) || cnt_term;

  always_comb begin
    state_d     = state_q;
    digit_d     = digit_q;
    armed_d     = armed_q;
    hold_done_d = hold_done_q;
    cnt_clear_c = 1'b0;
    hr_d        = 1'b0;

    case (state_q)
      S_START: begin
        if (ir_start_c) begin
          state_d     = S_COUNTDOWN;
          digit_d     = DIGIT_FIRST;
          cnt_clear_c = 1'b1;
          hr_d        = 1'b1;
        end
      end

      S_COUNTDOWN: begin
        if (ir_restart_c) begin
          state_d = S_START;
          digit_d = '0;
        end else if (bus.nf_in && (cnt == DIGIT_LAST)) begin
          cnt_clear_c = 1'b1;
          digit_d     = digit_q - DIGIT_W'(1);
          if (digit_q == DIGIT_W'(1)) begin
            state_d = S_PLAY;
            armed_d = 1'b0;
            digit_d = '0;
          end
        end
      end

      S_PLAY: begin
        // First frame in play covers the health-reload latency.
        if (!armed_q) begin
          if (bus.nf_in) begin
            armed_d = 1'b1;
          end
        end else if (player_dead_c || opp_dead_c) begin
          cnt_clear_c = 1'b1;
          hold_done_d = 1'b0;
          if (player_dead_c && opp_dead_c) begin
            state_d = S_DRAW;
          end else if (player_dead_c) begin
            state_d = S_LOSE;
          end else begin
            state_d = S_WIN;
          end
        end else if (ir_restart_c) begin
          state_d = S_START;
        end
      end

      S_WIN, S_LOSE, S_DRAW: begin
        if (hold_ok_c) begin
          hold_done_d = 1'b1;
        end
        if (hold_ok_c && (ir_start_c || ir_restart_c)) begin
          state_d = S_START;
        end
      end

      default: begin
        state_d = S_START;
        digit_d = '0;
      end
    endcase

    disp_start_d = (state_d == S_START);
    cd_active_d  = (state_d == S_COUNTDOWN);
    cd_digit_d   = (state_d == S_COUNTDOWN) ? digit_d : '0;
    game_d       = (state_d == S_PLAY);
    win_d        = (state_d == S_WIN);
    lose_d       = (state_d == S_LOSE);
    draw_d       = (state_d == S_DRAW);
    state_out_d  = state_d;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= S_START;
      digit_q      <= '0;
      armed_q      <= 1'b0;
      hold_done_q  <= 1'b0;
      disp_start_q <= 1'b1;
      cd_active_q  <= 1'b0;
      cd_digit_q   <= '0;
      game_q       <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
      draw_q       <= 1'b0;
      hr_q         <= 1'b0;
      state_out_q  <= S_START;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      armed_q      <= armed_d;
      hold_done_q  <= hold_done_d;
      disp_start_q <= disp_start_d;
      cd_active_q  <= cd_active_d;
      cd_digit_q   <= cd_digit_d;
      game_q       <= game_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
      draw_q       <= draw_d;
      hr_q         <= hr_d;
      state_out_q  <= state_out_d;
    end
  end

  assign bus.display_start_out    = disp_start_q;
  assign bus.countdown_active_out = cd_active_q;
  assign bus.countdown_digit_out  = cd_digit_q;
  assign bus.game_active_out      = game_q;
  assign bus.end_win_out          = win_q;
  assign bus.end_lose_out         = lose_q;
  assign bus.end_draw_out         = draw_q;
  assign bus.health_reset_out     = hr_q;
  assign bus.state_out            = state_out_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller: walks every screen transition and hold/priority boundary.
module tb_game_flow_controller;

  localparam logic [31:0] CODE_A   = 32'h20DF_5BA4;
  localparam logic [31:0] CODE_B   = 32'h20DF_5AA5;
  localparam logic [31:0] CODE_RST = 32'h20DF_10EF;
  localparam logic [31:0] CODE_X   = 32'h1234_5678;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  game_flow_controller_if bus();

  game_flow_controller dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  // Expected output vector {start, cd, digit, game, win, lose, draw, hr, state}.
  function automatic logic [11:0] ev(input logic [2:0] st, input logic [1:0] dg, input logic hr);
    return {st == 3'd0, st == 3'd1, dg, st == 3'd2, st == 3'd3, st == 3'd4, st == 3'd5, hr, st};
  endfunction

  function automatic logic [11:0] obs();
    return {bus.display_start_out, bus.countdown_active_out, bus.countdown_digit_out,
            bus.game_active_out, bus.end_win_out, bus.end_lose_out, bus.end_draw_out,
            bus.health_reset_out, bus.state_out};
  endfunction

  task automatic chk(input string tag, input logic [11:0] exp);
    logic [11:0] o;
    o = obs();
    n_vec++;
    assert (o === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, o, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] code, input logic nf);
    bus.ir_valid_in = v;
    bus.ir_in       = code;
    bus.nf_in       = nf;
    @(posedge clk);
    #1;
    bus.ir_valid_in = 1'b0;
    bus.nf_in       = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) step(1'b0, bus.ir_in, 1'b1);
  endtask

  task automatic to_play();
    step(1'b1, CODE_A, 1'b0);
    chk("start_a_entry", ev(3'd1, 2'd3, 1'b1));
    frames(180);
    chk("countdown_done", ev(3'd2, 2'd0, 1'b0));
  endtask

  initial begin
    rst_n                  = 1'b0;
    bus.ir_in              = '0;
    bus.ir_valid_in        = 1'b0;
    bus.nf_in              = 1'b0;
    bus.player_health_in   = 3'd7;
    bus.opponent_health_in = 3'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", ev(3'd0, 2'd0, 1'b0));
    rst_n = 1'b1;

    // Level without strobe, unknown code and restart are all ignored at the menu.
    step(1'b0, CODE_A, 1'b0);
    chk("level_no_strobe", ev(3'd0, 2'd0, 1'b0));
    step(1'b1, CODE_X, 1'b0);
    chk("unknown_code", ev(3'd0, 2'd0, 1'b0));
    step(1'b1, CODE_RST, 1'b0);
    chk("restart_at_menu", ev(3'd0, 2'd0, 1'b0));

    step(1'b1, CODE_A, 1'b0);
    chk("enter_countdown", ev(3'd1, 2'd3, 1'b1));
    step(1'b0, CODE_A, 1'b0);
    chk("hr_one_cycle", ev(3'd1, 2'd3, 1'b0));
    frames(59);
    chk("digit3_f59", ev(3'd1, 2'd3, 1'b0));
    frames(1);
    chk("digit2_f60", ev(3'd1, 2'd2, 1'b0));
    frames(60);
    chk("digit1_f120", ev(3'd1, 2'd1, 1'b0));
    frames(59);
    chk("digit1_f179", ev(3'd1, 2'd1, 1'b0));
    frames(1);
    chk("play_f180", ev(3'd2, 2'd0, 1'b0));

    // Unarmed play ignores dead player until the first frame.
    bus.player_health_in = 3'd0;
    step(1'b0, CODE_A, 1'b0);
    chk("unarmed_ignore", ev(3'd2, 2'd0, 1'b0));
    frames(1);
    chk("arming_frame", ev(3'd2, 2'd0, 1'b0));
    step(1'b0, CODE_A, 1'b0);
    chk("lose", ev(3'd4, 2'd0, 1'b0));
    bus.player_health_in = 3'd7;
    step(1'b0, CODE_A, 1'b0);
    chk("lose_health_ignored", ev(3'd4, 2'd0, 1'b0));
    frames(120);
    step(1'b1, CODE_B, 1'b0);
    chk("lose_exit_code_b", ev(3'd0, 2'd0, 1'b0));

    // Restart beats a same-cycle frame tick in countdown.
    step(1'b1, CODE_B, 1'b0);
    chk("start_b_entry", ev(3'd1, 2'd3, 1'b1));
    frames(10);
    step(1'b1, CODE_RST, 1'b1);
    chk("cd_restart_prio", ev(3'd0, 2'd0, 1'b0));

    to_play();
    step(1'b1, CODE_A, 1'b0);
    chk("play_start_ignored", ev(3'd2, 2'd0, 1'b0));
    frames(1);
    bus.opponent_health_in = 3'd0;
    step(1'b0, CODE_A, 1'b0);
    chk("win", ev(3'd3, 2'd0, 1'b0));
    frames(50);
    step(1'b1, CODE_RST, 1'b0);
    chk("win_hold_50", ev(3'd3, 2'd0, 1'b0));
    frames(69);
    step(1'b1, CODE_RST, 1'b0);
    chk("win_hold_119", ev(3'd3, 2'd0, 1'b0));
    frames(1);
    step(1'b1, CODE_RST, 1'b0);
    chk("win_exit_120", ev(3'd0, 2'd0, 1'b0));
    bus.opponent_health_in = 3'd7;

    to_play();
    frames(1);
    step(1'b1, CODE_RST, 1'b0);
    chk("play_restart", ev(3'd0, 2'd0, 1'b0));

    // Health event beats a same-cycle restart strobe.
    to_play();
    frames(1);
    bus.player_health_in   = 3'd0;
    bus.opponent_health_in = 3'd0;
    step(1'b1, CODE_RST, 1'b0);
    chk("draw_over_restart", ev(3'd5, 2'd0, 1'b0));
    bus.player_health_in   = 3'd7;
    bus.opponent_health_in = 3'd7;

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_draw", ev(3'd0, 2'd0, 1'b0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, CODE_A, 1'b0);
    chk("restart_after_rst", ev(3'd1, 2'd3, 1'b1));
    frames(30);
    chk("mid_countdown", ev(3'd1, 2'd3, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cd", ev(3'd0, 2'd0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_hr", ev(3'd0, 2'd0, 1'b0));
    rst_n = 1'b1;
    step(1'b0, CODE_A, 1'b0);
    chk("post_rst_idle", ev(3'd0, 2'd0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Top-level game sequencer for the display path.
- Decodes remote IR codes and tracks frame ticks and both health values. Steps the game through start menu, countdown, play, and win/lose/draw screens.
- Drives the screen-select flags and a health-reset pulse consumed by the display mux and game-state logic.
- Replaces ad-hoc start/end flag logic with a single registered FSM.

Parameters:
- START_CODE_A, 32'h20DF_5BA4, IR code that starts a game.
- START_CODE_B, 32'h20DF_5AA5, alternate IR start code.
- RESTART_CODE, 32'h20DF_10EF, IR code that aborts or returns to the start menu.
- COUNT_DIGITS, 3, first countdown digit shown (counts COUNT_DIGITS..1).
- FRAMES_PER_DIGIT, 60, nf_in ticks per countdown digit.
- END_HOLD_FRAMES, 120, minimum nf_in ticks on an end screen before IR input is accepted.

Ports:
- clk_in  input  1  system/pixel clock.
- rst_in  input  1  asynchronous, active-low reset.
- ir_in  input  32  last decoded IR code.
- ir_valid_in  input  1  one-cycle strobe; ir_in is valid and new this cycle.
- nf_in  input  1  one-cycle new-frame strobe.
- player_health_in  input  3  current player health.
- opponent_health_in  input  3  current opponent health.
- display_start_out  output  1  show start menu.
- countdown_active_out  output  1  countdown overlay active.
- countdown_digit_out  output  2  digit to draw while counting; 0 otherwise.
- game_active_out  output  1  gameplay running; sabers and attacks enabled.
- end_win_out  output  1  show win screen.
- end_lose_out  output  1  show lose screen.
- end_draw_out  output  1  show draw screen.
- health_reset_out  output  1  one-cycle pulse; game logic reloads full health.
- state_out  output  3  encoded FSM state, for debug/ILA.

Behaviour:
- Reset (rst_in low, asynchronous):
  - state = S_START.
  - display_start_out = 1; every other output = 0.
  - Frame counter = 0, digit = 0, armed = 0, hold_done = 0.
- All outputs are registered and decoded from the next state, so outputs change on the same edge as the state.
- IR codes are evaluated only in cycles where ir_valid_in = 1. Repeated level on ir_in without a strobe is ignored.
- S_START:
  - Code A or B → S_COUNTDOWN.
  - On entry: digit = COUNT_DIGITS, frame counter = 0, health_reset_out pulses for exactly 1 cycle.
  - All other codes are ignored.
- S_COUNTDOWN:
  - Each nf_in increments the frame counter.
  - When the counter equals FRAMES_PER_DIGIT-1 and nf_in = 1: counter clears and digit decrements.
  - If digit was 1 at that point → S_PLAY with armed = 0.
  - RESTART_CODE → S_START, with priority over the frame tick in the same cycle.
- S_PLAY:
  - Health checks are suppressed until armed = 1. armed sets on the first nf_in in S_PLAY, which covers the health-reload latency.
  - Once armed, priority order:
    - both healths 0 → S_DRAW;
    - player 0 → S_LOSE;
    - opponent 0 → S_WIN;
    - RESTART_CODE → S_START.
  - A health event beats an IR strobe in the same cycle.
  - Start codes are ignored.
- S_WIN / S_LOSE / S_DRAW:
  - The frame counter clears on entry and counts nf_in, saturating.
  - hold_done sets when the count reaches END_HOLD_FRAMES.
  - Before hold_done, all IR is ignored.
  - After hold_done, code A, code B, or RESTART → S_START.
  - Health inputs are ignored.
- Width rules:
  - Frame counter width = $clog2(max(FRAMES_PER_DIGIT, END_HOLD_FRAMES)+1).
  - The counter saturates at its terminal value and never wraps.
- Exactly one of display_start/countdown_active/game_active/end_* is high at all times after reset.
- Reset asserted mid-game returns to S_START immediately. No health_reset_out pulse is generated by reset.

Decomposition:
- game_flow_pkg holds:
  - the state typedef: enum logic [2:0] {S_START, S_COUNTDOWN, S_PLAY, S_WIN, S_LOSE, S_DRAW};
  - the default IR code localparams.
- One sub-module: frame_tick_counter.
  - Inputs: clear, nf tick.
  - Parameterised terminal value, saturating.
  - Outputs: count and terminal flag.
  - Instantiated once and shared across countdown and end-hold use.

Test Plan:
- Reset release, then ir_valid with 32'h20DF_5BA4 → health_reset_out high 1 cycle, countdown_digit_out = 3, countdown_active_out = 1.
- From S_COUNTDOWN, 180 nf_in pulses (FRAMES_PER_DIGIT = 60) → digit sequence 3→2→1. game_active_out = 1 on the edge of the 180th pulse.
- In S_PLAY before the first nf_in, player_health_in = 0 → stays in S_PLAY. After one nf_in with player health still 0 → end_lose_out = 1.
- Armed S_PLAY, both healths drop to 0 in the same cycle as ir_valid with RESTART_CODE → end_draw_out = 1, not display_start_out.
- In S_WIN, RESTART strobe after 50 frames → ignored. Strobe after 120 frames → display_start_out = 1 next edge.
- Assert rst_in low mid-countdown, asynchronously between clock edges → display_start_out = 1 immediately and health_reset_out stays 0.
